// File: rtl/encoder_decimal_to_bcd_basic_gates_pkg.sv
// Shared widths, BCD digit codes and mode selectors for the decimal-to-BCD encoder.
package encoder_decimal_to_bcd_basic_gates_pkg;

  localparam int BCD_W = 4;
  localparam int DEC_W = 10;

  localparam logic [BCD_W-1:0] DIGIT_0 = 4'd0;
  localparam logic [BCD_W-1:0] DIGIT_1 = 4'd1;
  localparam logic [BCD_W-1:0] DIGIT_2 = 4'd2;
  localparam logic [BCD_W-1:0] DIGIT_3 = 4'd3;
  localparam logic [BCD_W-1:0] DIGIT_4 = 4'd4;
  localparam logic [BCD_W-1:0] DIGIT_5 = 4'd5;
  localparam logic [BCD_W-1:0] DIGIT_6 = 4'd6;
  localparam logic [BCD_W-1:0] DIGIT_7 = 4'd7;
  localparam logic [BCD_W-1:0] DIGIT_8 = 4'd8;
  localparam logic [BCD_W-1:0] DIGIT_9 = 4'd9;

  localparam logic [BCD_W-1:0] DIGITS [DEC_W] = '{
    DIGIT_0, DIGIT_1, DIGIT_2, DIGIT_3, DIGIT_4,
    DIGIT_5, DIGIT_6, DIGIT_7, DIGIT_8, DIGIT_9
  };

  localparam int MODE_OR   = 0;
  localparam int MODE_PRIO = 1;

endpackage

// File: rtl/encoder_decimal_to_bcd_basic_gates_if.sv
// Switch-bank input and registered BCD result bundle. No handshake: the
// encoder samples signal_i on every rising clock edge and results follow one cycle later.
interface encoder_decimal_to_bcd_basic_gates_if;
  import encoder_decimal_to_bcd_basic_gates_pkg::*;

  logic [DEC_W-1:0] signal_i;
  logic [BCD_W-1:0] signal_o;
  logic             valid_o;
  logic             error_o;

  modport master (output signal_i, input signal_o, input valid_o, input error_o);
  modport slave  (input signal_i, output signal_o, output valid_o, output error_o);
endinterface

// File: rtl/encoder_decimal_to_bcd_basic_gates_dec_bcd_gate_core.sv
// Combinational encoding core: OR-gate BCD equations, highest-line priority
// code and a population check separating one-hot from multi-hot inputs.
module dec_bcd_gate_core
  import encoder_decimal_to_bcd_basic_gates_pkg::*;
(
  input  logic [DEC_W-1:0] lines,
  output logic [BCD_W-1:0] or_code,
  output logic [BCD_W-1:0] prio_code,
  output logic             one_hot,
  output logic             multi_hot
);

  // Line 0 feeds no output bit; digit 0 is only distinguishable via one_hot.
  assign or_code[0] = lines[1] | lines[3] | lines[5] | lines[7] | lines[9];
  assign or_code[1] = lines[2] | lines[3] | lines[6] | lines[7];
  assign or_code[2] = lines[4] | lines[5] | lines[6] | lines[7];
  assign or_code[3] = lines[8] | lines[9];

  always_comb begin
    prio_code = DIGIT_0;
    for (int i = 0; i < DEC_W; i++) begin
      if (lines[i]) prio_code = DIGITS[i];
    end
  end

  // Clearing the lowest set bit leaves something only when two or more lines are high.
  assign multi_hot = |(lines & (lines - 10'd1));
  assign one_hot   = (|lines) & ~multi_hot;

endmodule

// File: rtl/encoder_decimal_to_bcd_basic_gates.sv
// Registered 10-line decimal-to-BCD encoder; one-cycle latency from signal_i
// to signal_o/valid_o/error_o, synchronous active-low reset.
module encoder_decimal_to_bcd_basic_gates
  import encoder_decimal_to_bcd_basic_gates_pkg::*;
#(
  parameter int PRIORITY_MODE = MODE_OR,
  parameter int IN_W          = DEC_W
) (
  input  logic clk_i,
  input  logic rst_ni,
  encoder_decimal_to_bcd_basic_gates_if.slave bus
);

  logic [IN_W-1:0]  sample;
  logic [BCD_W-1:0] or_code;
  logic [BCD_W-1:0] prio_code;
  logic [BCD_W-1:0] code;
  logic             one_hot;
  logic             multi_hot;

  assign sample = bus.signal_i;

  dec_bcd_gate_core u_core (
    .lines     (sample),
    .or_code   (or_code),
    .prio_code (prio_code),
    .one_hot   (one_hot),
    .multi_hot (multi_hot)
  );

  assign code = (PRIORITY_MODE == MODE_PRIO) ? prio_code : or_code;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bus.signal_o <= DIGIT_0;
      bus.valid_o  <= 1'b0;
      bus.error_o  <= 1'b0;
    end else begin
      bus.signal_o <= code;
      bus.valid_o  <= one_hot;
      bus.error_o  <= multi_hot;
    end
  end

endmodule

// File: tb/tb_encoder_decimal_to_bcd_basic_gates.sv
// Bench for the decimal-to-BCD encoder: both modes run side by side on the same
// switch inputs and are compared against a set-of-lines reference model.
module tb_encoder_decimal_to_bcd_basic_gates;

  logic       clk;
  logic       rst_n;
  logic [9:0] sig_i;

  logic [3:0] sig_o [2];
  logic       val_o [2];
  logic       err_o [2];

  int n_vec;
  int n_err;

  encoder_decimal_to_bcd_basic_gates_if if0 ();
  encoder_decimal_to_bcd_basic_gates_if if1 ();

  assign if0.signal_i = sig_i;
  assign if1.signal_i = sig_i;
  assign sig_o[0] = if0.signal_o;
  assign val_o[0] = if0.valid_o;
  assign err_o[0] = if0.error_o;
  assign sig_o[1] = if1.signal_o;
  assign val_o[1] = if1.valid_o;
  assign err_o[1] = if1.error_o;

  encoder_decimal_to_bcd_basic_gates #(.PRIORITY_MODE(0)) dut_or (
    .clk_i (clk), .rst_ni (rst_n), .bus (if0)
  );
  encoder_decimal_to_bcd_basic_gates #(.PRIORITY_MODE(1)) dut_prio (
    .clk_i (clk), .rst_ni (rst_n), .bus (if1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: treat the input as a set of pressed digits.
  function automatic void model(input logic [9:0] v, input int mode,
                                output logic [3:0] code, output logic vld, output logic err);
    int cnt;
    int acc;
    int hi;
    cnt = 0; acc = 0; hi = 0;
    for (int k = 0; k < 10; k++) begin
      if (v[k]) begin
        cnt++;
        acc = acc | k;
        hi  = k;
      end
    end
    code = (mode == 1) ? 4'(hi) : 4'(acc);
    vld  = (cnt == 1);
    err  = (cnt >= 2);
  endfunction

  task automatic apply(input logic [9:0] v);
    @(negedge clk);
    sig_i = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] junk;
    rst_n = 1'b0;
    junk  = 10'($urandom_range(1, 1023));
    sig_i = junk;
    repeat (3) @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if ({sig_o[m], val_o[m], err_o[m]} !== 6'b0) begin
        n_err++;
        $display("FAIL reset m%0d got code=%0d v=%b e=%b want code=0 v=0 e=0",
                 m, sig_o[m], val_o[m], err_o[m]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_one_hot_walk();
    logic [3:0] ec; logic ev, ee;
    for (int d = 0; d < 10; d++) begin
      apply(10'd1 << d);
      for (int m = 0; m < 2; m++) begin
        model(sig_i, m, ec, ev, ee);
        n_vec++;
        if ({sig_o[m], val_o[m], err_o[m]} !== {4'(d), 1'b1, 1'b0} ||
            {sig_o[m], val_o[m], err_o[m]} !== {ec, ev, ee}) begin
          n_err++;
          $display("FAIL walk m%0d d=%0d got code=%0d v=%b e=%b want code=%0d v=1 e=0",
                   m, d, sig_o[m], val_o[m], err_o[m], d);
        end
      end
    end
  endtask

  task automatic test_idle();
    apply(10'd0);
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if ({sig_o[m], val_o[m], err_o[m]} !== 6'b0) begin
        n_err++;
        $display("FAIL idle m%0d got code=%0d v=%b e=%b want code=0 v=0 e=0",
                 m, sig_o[m], val_o[m], err_o[m]);
      end
    end
  endtask

  task automatic test_multi_hot();
    logic [9:0] pats [4];
    logic [3:0] want [4][2];
    pats[0] = 10'b00_0010_1000; want[0][0] = 4'd7;  want[0][1] = 4'd5;
    pats[1] = 10'b11_1111_1111; want[1][0] = 4'd15; want[1][1] = 4'd9;
    pats[2] = 10'b01_1000_0000; want[2][0] = 4'd15; want[2][1] = 4'd8;
    pats[3] = 10'b00_0000_0011; want[3][0] = 4'd1;  want[3][1] = 4'd1;
    for (int p = 0; p < 4; p++) begin
      apply(pats[p]);
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if ({sig_o[m], val_o[m], err_o[m]} !== {want[p][m], 1'b0, 1'b1}) begin
          n_err++;
          $display("FAIL multi m%0d in=%b got code=%0d v=%b e=%b want code=%0d v=0 e=1",
                   m, pats[p], sig_o[m], val_o[m], err_o[m], want[p][m]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    apply(10'b10_0000_0000);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if ({sig_o[m], val_o[m], err_o[m]} !== 6'b0) begin
        n_err++;
        $display("FAIL reset_mid m%0d got code=%0d v=%b e=%b want code=0 v=0 e=0",
                 m, sig_o[m], val_o[m], err_o[m]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if ({sig_o[m], val_o[m], err_o[m]} !== {4'd9, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL reset_release m%0d got code=%0d v=%b e=%b want code=9 v=1 e=0",
                 m, sig_o[m], val_o[m], err_o[m]);
      end
    end
  endtask

  task automatic test_latency();
    logic [3:0] ec; logic ev, ee;
    logic [9:0] a, b;
    a = 10'b00_0001_0000;
    b = 10'b00_1000_0100;
    apply(a);
    #2 sig_i = b;
    #2;
    for (int m = 0; m < 2; m++) begin
      model(a, m, ec, ev, ee);
      n_vec++;
      if ({sig_o[m], val_o[m], err_o[m]} !== {ec, ev, ee}) begin
        n_err++;
        $display("FAIL latency_hold m%0d got code=%0d v=%b e=%b want code=%0d v=%b e=%b",
                 m, sig_o[m], val_o[m], err_o[m], ec, ev, ee);
      end
    end
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      model(b, m, ec, ev, ee);
      n_vec++;
      if ({sig_o[m], val_o[m], err_o[m]} !== {ec, ev, ee}) begin
        n_err++;
        $display("FAIL latency_update m%0d got code=%0d v=%b e=%b want code=%0d v=%b e=%b",
                 m, sig_o[m], val_o[m], err_o[m], ec, ev, ee);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] ec; logic ev, ee;
    logic [9:0] v;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0:       v = 10'd1 << $urandom_range(0, 9);
        1:       v = (10'd1 << $urandom_range(0, 9)) | (10'd1 << $urandom_range(0, 9));
        2:       v = 10'd0;
        default: v = 10'($urandom_range(0, 1023));
      endcase
      apply(v);
      for (int m = 0; m < 2; m++) begin
        model(v, m, ec, ev, ee);
        n_vec++;
        if ({sig_o[m], val_o[m], err_o[m]} !== {ec, ev, ee}) begin
          n_err++;
          $display("FAIL random m%0d in=%b got code=%0d v=%b e=%b want code=%0d v=%b e=%b",
                   m, v, sig_o[m], val_o[m], err_o[m], ec, ev, ee);
        end
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    sig_i = 10'd0;
    test_reset();
    test_one_hot_walk();
    test_idle();
    test_multi_hot();
    test_reset_mid();
    test_latency();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
